conv_sched: RTL
===============

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter N, default 4, image side length in pixels; legal range N >= K_SIZE.
REQ-002 SHALL have parameter K_SIZE, default 3, kernel side length; legal range 1 <= K_SIZE <= N.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, pixel-memory address width; N*N SHALL fit in ADDR_WIDTH bits.
REQ-004 SHALL define CW = max(1, $clog2(N)) for coordinate widths.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start_i  input  1  one-cycle request to process one N*N frame.
REQ-008 busy_o  output  1  frame in progress.
REQ-009 done_o  output  1  one-cycle pulse: frame complete.
REQ-010 mem_en_o  output  1  pixel-memory read enable (1-cycle read latency).
REQ-011 mem_addr_o  output  ADDR_WIDTH  pixel-memory read address, raster order.
REQ-012 conv_en_o  output  1  convolutor shift/compute enable; one pixel accepted per asserted cycle.
REQ-013 out_valid_o  output  1  convolutor data output holds a valid window result.
REQ-014 out_ready_i  input  1  downstream accepts result when out_valid_o && out_ready_i.
REQ-015 out_row_o, out_col_o  output  CW each  top-left coordinate of current window.

Function
REQ-016 States: IDLE, RUN, DRAIN; done_o is a registered pulse on the DRAIN->IDLE transition.
REQ-017 IDLE: start_i=1 -> RUN next cycle; start_i while busy_o=1 SHALL be ignored.
REQ-018 stall = out_valid_o && !out_ready_i; during stall mem_en_o=0, conv_en_o=0, every counter, address and flag holds.
REQ-019 Read counter rd_cnt (0..N*N): in RUN, mem_en_o = !stall && rd_cnt < N*N, mem_addr_o = rd_cnt; rd_cnt increments per issued read.
REQ-020 Pending flag pend: set the cycle after an issued read; conv_en_o = pend && !stall; pend clears after a push with no new read.
REQ-021 Unstalled streaming: pixel p pushed exactly one cycle after its read; one pixel per cycle, no bubbles.
REQ-022 Push counters row/col track pushed pixel; col wraps N-1 -> 0 with row increment.
REQ-023 Push of pixel (row, col) with row >= K_SIZE-1 and col >= K_SIZE-1 SHALL set out_valid_o next cycle, out_row_o = row-K_SIZE+1, out_col_o = col-K_SIZE+1.
REQ-024 out_valid_o clears after handshake unless a qualifying push occurs in the same cycle (new result loads; no bubble).
REQ-025 Total results per frame = (N-K_SIZE+1)^2, raster order.
REQ-026 After push of pixel N*N-1: RUN -> DRAIN; DRAIN exits when the final result handshakes; done_o=1 the following cycle, state IDLE.
REQ-027 busy_o = 1 from the cycle after accepted start_i until the cycle done_o asserts (busy_o=0 in done_o cycle).
REQ-028 start_i in the done_o cycle SHALL be accepted (new frame).
REQ-029 K_SIZE=1: every pixel produces a result; N=K_SIZE: exactly one result at (0,0).

Reset
REQ-030 rst=1 (any state, incl. mid-frame or stalled): next cycle IDLE, busy_o=0, done_o=0, mem_en_o=0, conv_en_o=0, out_valid_o=0, mem_addr_o=0, out_row_o=0, out_col_o=0, all counters and pend cleared.
REQ-031 rst has priority over start_i and out_ready_i.

Verification
REQ-032 N=4,K=3, out_ready_i=1, start_i at cycle 0 -> mem_en_o cycles 1-16 addr 0-15; conv_en_o cycles 2-17; out_valid_o at cycles 13,14,17,18 with (row,col)=(0,0),(0,1),(1,0),(1,1); done_o cycle 19; busy_o cycles 1-18.
REQ-033 Same, out_ready_i=0 cycles 13-15 -> out_valid_o held with (0,0), mem_en_o/conv_en_o low, mem_addr_o frozen; remaining sequence shifted 3 cycles, done_o cycle 22.
REQ-034 N=4,K=1 -> 16 results (0,0)..(3,3) on consecutive cycles 3-18, done_o cycle 19.
REQ-035 N=3,K=3 -> single result (0,0) at cycle 11, done_o cycle 12; start_i pulses at cycles 5 and 12 -> cycle-5 ignored, cycle-12 starts second frame.
REQ-036 rst asserted at cycle 8 of REQ-032 frame -> cycle 9 all outputs reset values; new start_i at cycle 10 reproduces REQ-032 timing offset by 10.

Source files
------------

// File: rtl/conv_sched_if.sv
// conv_sched_if -- bus between the convolution scheduler and its environment.
//   start_i / busy_o / done_o      : frame request and status
//   mem_en_o / mem_addr_o          : pixel-memory read port (1-cycle latency)
//   conv_en_o                      : convolutor shift/compute enable
//   out_valid_o / out_ready_i      : window-result handshake
//   out_row_o / out_col_o          : top-left coordinate of the current window
// master = scheduler side, slave = environment side.
interface conv_sched_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int CW         = 2
);
   logic                  start_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  mem_en_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  conv_en_o;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [CW-1:0]         out_row_o;
   logic [CW-1:0]         out_col_o;

   modport master (
      input  start_i, out_ready_i,
      output busy_o, done_o, mem_en_o, mem_addr_o, conv_en_o,
             out_valid_o, out_row_o, out_col_o
   );

   modport slave (
      output start_i, out_ready_i,
      input  busy_o, done_o, mem_en_o, mem_addr_o, conv_en_o,
             out_valid_o, out_row_o, out_col_o
   );
endinterface

// File: rtl/conv_sched.sv
// conv_sched -- sequences one N*N frame of pixels from memory into a
// K_SIZE x K_SIZE sliding-window convolutor and tags each window result.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : conv_sched_if.master (start/busy/done, memory read port,
//         convolutor enable, result handshake + window coordinate)
// A stalled result (valid && !ready) freezes reads, pushes and all counters.
module conv_sched #(
   parameter int N          = 4,
   parameter int K_SIZE     = 3,
   parameter int ADDR_WIDTH = 14
) (
   input  logic         clk,
   input  logic         rst,
   conv_sched_if.master bus
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [ADDR_WIDTH-1:0] PIX  = ADDR_WIDTH'(N * N);
   localparam logic [CW-1:0]         LAST = CW'(N - 1);
   localparam logic [CW-1:0]         KM1  = CW'(K_SIZE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] rd_cnt;
   logic                  pend;
   logic [CW-1:0]         row, col;
   logic                  out_valid;
   logic [CW-1:0]         out_row, out_col;
   logic                  done;

   logic stall, hs, rd_go, push, busy, win_ok, last_px;

   assign stall   = out_valid && !bus.out_ready_i;
   assign hs      = out_valid && bus.out_ready_i;
   assign last_px = (row == LAST) && (col == LAST);

   // Window is complete once the pushed pixel sits at or past the kernel's
   // bottom-right corner; with a 1x1 kernel every pixel qualifies.
   generate
      if (K_SIZE == 1) begin : g_k1
         assign win_ok = 1'b1;
      end else begin : g_kn
         assign win_ok = (row >= KM1) && (col >= KM1);
      end
   endgenerate

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start_i)      state_nxt = RUN;
         RUN:     if (push && last_px)  state_nxt = DRAIN;
         DRAIN:   if (hs)               state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy  = 1'b0;
      rd_go = 1'b0;
      push  = 1'b0;
      case (state)
         RUN: begin
            busy  = 1'b1;
            rd_go = !stall && (rd_cnt < PIX);
            push  = pend && !stall;
         end
         DRAIN:   busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt    <= '0;
         pend      <= 1'b0;
         row       <= '0;
         col       <= '0;
         out_valid <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
         done      <= 1'b0;
      end else begin
         // The final result always handshakes in DRAIN, so this is the
         // last cycle of the frame.
         done <= (state == DRAIN) && hs;

         if (state == IDLE) begin
            rd_cnt <= '0;
            pend   <= 1'b0;
            row    <= '0;
            col    <= '0;
         end else if (!stall) begin
            if (rd_go) rd_cnt <= rd_cnt + 1'b1;
            // memory data lands one cycle after the read
            pend <= rd_go;
            if (push) begin
               if (col == LAST) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
         end

         // A qualifying push reloads the result slot in the same cycle the
         // old result leaves, so back-to-back results carry no bubble.
         if (push && win_ok) begin
            out_valid <= 1'b1;
            out_row   <= row - KM1;
            out_col   <= col - KM1;
         end else if (hs) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.busy_o      = busy;
   assign bus.done_o      = done;
   assign bus.mem_en_o    = rd_go;
   assign bus.mem_addr_o  = rd_cnt;
   assign bus.conv_en_o   = push;
   assign bus.out_valid_o = out_valid;
   assign bus.out_row_o   = out_row;
   assign bus.out_col_o   = out_col;
endmodule
